// File: rtl/store_writer.sv
// store_writer
//   Writes the low 1, 2 or 4 bytes of a register value to a byte-wide memory
//   bus, one byte per cycle, in little-endian order. It sits between the
//   load/store buffer commit point and the memory arbiter. It waits on the
//   arbiter grant, the global ready and, for IO-region stores, the IO write
//   buffer full flag.
//
// Ports
//   clk_in, rst_in        clock (rising edge); asynchronous active-high reset
//   rdy_in                global ready; low freezes state and blocks writes
//   req_valid/req_ready   store request handshake
//   req_addr, req_data    byte address of lowest byte, register value
//   req_is_byte/half/word access size (word > byte > half; none = 0 bytes)
//   mem_grant             arbiter grants the bus this cycle
//   io_buffer_full        IO write buffer cannot take a byte
//   mem_a, mem_dout       write address / byte, zero when mem_wr is low
//   mem_wr                byte committed at the clock edge where this is high
//   busy                  request accepted and not yet completed
//   done                  one-cycle completion pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; req_ready follows rdy_in
// WRITE  | emitting byte idx of the latched value, holding on a stall
// DONE   | pulse done when rdy_in is high, then go back to IDLE

module store_writer #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,   // only 32 is supported
  parameter logic [1:0] IO_ADDR_BITS = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_is_byte,
  input  logic                  req_is_half,
  input  logic                  req_is_word,
  input  logic                  mem_grant,
  input  logic                  io_buffer_full,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [2:0]            count_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [2:0] req_count;
  logic       io_region;
  logic       stall;
  logic       accept;
  logic       wr_fire;
  logic       last_byte;
  logic [7:0] byte_sel;

  // Word wins over byte, byte over half; a request with no size flag is
  // accepted and completes without touching the bus.
  always_comb begin
    req_count = 3'd0;
    if (req_is_word)      req_count = 3'd4;
    else if (req_is_byte) req_count = 3'd1;
    else if (req_is_half) req_count = 3'd2;
  end

  // The IO decision uses the latched base, so every byte of one store is
  // gated the same way even if later bytes cross into another region.
  assign io_region = (base_q[17:16] == IO_ADDR_BITS);
  assign stall     = !rdy_in || !mem_grant || (io_region && io_buffer_full);

  assign accept    = (state_q == S_IDLE) && rdy_in && req_valid;
  assign wr_fire   = (state_q == S_WRITE) && !stall;
  assign last_byte = ({1'b0, idx_q} == (count_q - 3'd1));
  assign byte_sel  = data_q[{idx_q, 3'b000} +: 8];

  assign req_ready = (state_q == S_IDLE) && rdy_in;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) && rdy_in;

  // Bus is held at zero whenever no byte is being committed.
  assign mem_wr    = wr_fire;
  assign mem_a     = wr_fire ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign mem_dout  = wr_fire ? byte_sel : 8'h00;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      count_q <= 3'd0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            base_q  <= req_addr;
            data_q  <= req_data;
            count_q <= req_count;
            idx_q   <= 2'd0;
            state_q <= (req_count == 3'd0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            idx_q <= idx_q + 2'd1;
            if (last_byte) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (rdy_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_writer.md
Name: store_writer

Overview:
- Store-side counterpart of the load-path extender: takes a register value plus access size and writes the low 1/2/4 bytes to the byte-wide memory bus, one byte per cycle, little-endian.
- Sits between the load/store buffer commit point and the memory arbiter.
- Honours the arbiter grant, the global ready and the IO write-buffer full flag.

Parameters:
- ADDR_WIDTH, 32, memory address width; wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, register width (`REG_TYPE); must be 32.
- IO_ADDR_BITS, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state and suppresses writes.
- req_valid  input  1  store request present.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  ADDR_WIDTH  byte address of lowest byte.
- req_data  input  DATA_WIDTH  register value to store.
- req_is_byte  input  1  store 1 byte.
- req_is_half  input  1  store 2 bytes.
- req_is_word  input  1  store 4 bytes.
- mem_grant  input  1  arbiter grants the memory bus this cycle.
- io_buffer_full  input  1  IO write buffer full.
- mem_a  output  ADDR_WIDTH  write address.
- mem_dout  output  8  write byte.
- mem_wr  output  1  write strobe; byte committed at the clock edge where it is high.
- busy  output  1  request accepted and not yet completed.
- done  output  1  one-cycle pulse when the store completes.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, count=0, base and data regs=0, done=0. Outputs req_ready=1, mem_wr=0, mem_a=0, mem_dout=0, busy=0. A store interrupted by reset is abandoned; it performs no further writes and no done pulse.
- Size decode, priority order: is_word gives 4 bytes; else is_byte gives 1; else is_half gives 2; none set gives 0 bytes.
- IDLE state:
  - req_ready = rdy_in.
  - On req_valid && req_ready, latch addr, data and count, set idx=0.
  - If count > 0, go to WRITE; if count == 0, go to DONE.
- stall = !rdy_in || !mem_grant || (base[17:16]==IO_ADDR_BITS && io_buffer_full). The IO test uses the latched base address, so all bytes of one store share a single IO decision.
- WRITE state:
  - mem_wr = !stall.
  - mem_a = base + idx, truncated to ADDR_WIDTH, so wrap-around is allowed.
  - mem_dout = data[8*idx+7 : 8*idx].
  - On a non-stalled cycle, increment idx. When idx == count-1, go to DONE.
  - On a stalled cycle, mem_wr=0 and idx is held.
- mem_a and mem_dout are 0 whenever mem_wr=0.
- DONE state:
  - done=1 for exactly one cycle, gated by rdy_in; if rdy_in is low, DONE is held with done=0.
  - Return to IDLE.
- busy = (state != IDLE).
- req_ready = 0 outside IDLE, so back-to-back requests are spaced by at least one idle cycle.
- Latency with no stalls: request accepted at cycle T; writes in T+1 .. T+N; done at T+N+1; req_ready high again at T+N+2.
- Size inputs are sampled only at acceptance; changes during busy are ignored.
- Data bits above the store width are never driven onto the bus.

Test Plan:
- Word store: addr=0x1000, data=0xDEADBEEF, is_word, grant=1. Writes 0x1000:EF, 0x1001:BE, 0x1002:AD, 0x1003:DE on consecutive cycles; done 1 cycle after the last write; busy high throughout.
- Byte and half stores: byte store of data=0x12345678 at 0x20 writes exactly one byte, 0x20:78. Half store at 0x21 writes 0x21:78, 0x22:56. Bytes 0x34 and 0x12 never appear on mem_dout.
- Stalls: drop mem_grant for 3 cycles after the first byte of a word store. mem_wr=0 during the stall, idx held; the remaining 3 bytes follow in order after grant returns; done at T+8.
- IO gating: half store to 0x30000 with io_buffer_full=1 for 5 cycles gives no writes; after it clears, 0x30000 then 0x30001 are written. The same stall on a non-IO address (0x1000) has no effect.
- Wrap and no-size: word store at 0xFFFFFFFE writes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. A request with no size flag set gives zero writes and done at T+1.
- Reset mid-store: assert rst_in asynchronously after the 2nd byte of a word store. Outputs go to reset values immediately, no further writes, no done, req_ready=1 after reset release.
